// File: rtl/airlock_pkg.sv
// Shared types and constants for the lock-chamber sequencer.
package airlock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_OUTER = 3'd2,
    ST_DRAIN = 3'd3,
    ST_INNER = 3'd4
  } state_t;

  localparam int unsigned STATE_LSB    = 0;
  localparam int unsigned DIR_BIT      = 3;
  localparam int unsigned PEND_IN_BIT  = 4;
  localparam int unsigned PEND_OUT_BIT = 5;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_TIMER  = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

endpackage

// File: rtl/airlock_sequencer_if.sv
// Read-only Avalon-MM status port of the airlock sequencer.
interface airlock_sequencer_if;
  logic [1:0]  address;
  logic [31:0] readdata;

  modport master (output address, input  readdata);
  modport slave  (input  address, output readdata);
endinterface

// File: rtl/airlock_phase_timer.sv
// Loadable down-counter that times one chamber phase; holds at zero.
module airlock_phase_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  assign zero = (value == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (!zero) begin
      value <= value - CNT_W'(1);
    end
  end

endmodule

// File: rtl/airlock_sequencer.sv
// Runs the lock chamber through fill/door/drain phases for entry or exit,
// arbitrating pending requests round-robin; status readable over Avalon-MM.
module airlock_sequencer
  import airlock_pkg::*;
#(
  parameter int unsigned FILL_CYCLES  = 4,
  parameter int unsigned DRAIN_CYCLES = 5,
  parameter int unsigned DOOR_CYCLES  = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_in,
  input  logic                req_out,
  airlock_sequencer_if.slave  avs,
  output logic                filling,
  output logic                draining,
  output logic                outer_open,
  output logic                inner_open,
  output logic                busy
);

  state_t           state, state_next;
  logic             dir, last_dir;
  logic             pend_in, pend_out;
  logic             grant, grant_dir;
  logic             timer_load, timer_zero;
  logic [CNT_W-1:0] timer_load_value, timer_value;
  logic [15:0]      transit_cnt;
  logic [31:0]      status_word;

  assign grant     = (state == ST_IDLE) && (pend_in || pend_out);
  // On a tie, favour the direction that was not served last.
  assign grant_dir = (pend_in && pend_out) ? ~last_dir : pend_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (pend_in || pend_out)
                  state_next = (grant_dir == DIR_IN) ? ST_FILL : ST_INNER;
      ST_FILL:  if (timer_zero) state_next = ST_OUTER;
      ST_OUTER: if (timer_zero) state_next = ST_DRAIN;
      ST_DRAIN: if (timer_zero) state_next = (dir == DIR_IN) ? ST_INNER : ST_IDLE;
      ST_INNER: if (timer_zero) state_next = (dir == DIR_IN) ? ST_IDLE : ST_FILL;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    filling    = (state == ST_FILL);
    draining   = (state == ST_DRAIN);
    outer_open = (state == ST_OUTER);
    inner_open = (state == ST_INNER);
    busy       = (state != ST_IDLE);
  end

  // The grant clears its own pend and absorbs a same-direction request that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir      <= DIR_IN;
      last_dir <= DIR_OUT;
      pend_in  <= 1'b0;
      pend_out <= 1'b0;
    end else if (grant) begin
      dir      <= grant_dir;
      last_dir <= grant_dir;
      pend_in  <= (grant_dir == DIR_IN)  ? 1'b0 : (pend_in  | req_in);
      pend_out <= (grant_dir == DIR_OUT) ? 1'b0 : (pend_out | req_out);
    end else begin
      pend_in  <= pend_in  | req_in;
      pend_out <= pend_out | req_out;
    end
  end

  assign timer_load = (state_next != state) && (state_next != ST_IDLE);

  always_comb begin
    timer_load_value = '0;
    case (state_next)
      ST_FILL:            timer_load_value = CNT_W'(FILL_CYCLES - 1);
      ST_DRAIN:           timer_load_value = CNT_W'(DRAIN_CYCLES - 1);
      ST_OUTER, ST_INNER: timer_load_value = CNT_W'(DOOR_CYCLES - 1);
      default:            timer_load_value = '0;
    endcase
  end

  airlock_phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_value (timer_load_value),
    .value      (timer_value),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      transit_cnt <= '0;
    end else if ((state != ST_IDLE) && (state_next == ST_IDLE)) begin
      transit_cnt <= transit_cnt + 16'd1;
    end
  end

  always_comb begin
    status_word                       = '0;
    status_word[STATE_LSB +: 3]       = state;
    status_word[DIR_BIT]              = dir;
    status_word[PEND_IN_BIT]          = pend_in;
    status_word[PEND_OUT_BIT]         = pend_out;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs.readdata <= '0;
    end else begin
      case (avs.address)
        ADDR_STATUS: avs.readdata <= status_word;
        ADDR_TIMER:  avs.readdata <= 32'(timer_value);
        ADDR_COUNT:  avs.readdata <= {16'b0, transit_cnt};
        default:     avs.readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_airlock_sequencer.sv
// Self-checking bench: a phase-list reference model predicts actuators and
// status reads cycle by cycle under directed and random request traffic.
module tb_airlock_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req_in = 1'b0;
  logic req_out = 1'b0;
  logic filling, draining, outer_open, inner_open, busy;
  logic [4:0] outs;

  int n_tests = 0;
  int n_fail  = 0;

  airlock_sequencer_if bus ();

  airlock_sequencer #(
    .FILL_CYCLES  (4),
    .DRAIN_CYCLES (5),
    .DOOR_CYCLES  (3),
    .CNT_W        (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_in     (req_in),
    .req_out    (req_out),
    .avs        (bus),
    .filling    (filling),
    .draining   (draining),
    .outer_open (outer_open),
    .inner_open (inner_open),
    .busy       (busy)
  );

  assign outs = {busy, filling, draining, outer_open, inner_open};

  always #5 clk = ~clk;

  // Reference model: phase codes 0 idle, 1 fill, 2 outer, 3 drain, 4 inner.
  int          m_seq[$];
  int          m_cur, m_left;
  bit          m_pi, m_po, m_dir, m_last;
  logic [15:0] m_cnt;
  logic [31:0] m_rd;

  function automatic int dur(int p);
    case (p)
      1:       return 4;
      3:       return 5;
      2, 4:    return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [4:0] exp_outs();
    return {m_cur != 0, m_cur == 1, m_cur == 3, m_cur == 2, m_cur == 4};
  endfunction

  task automatic model_reset();
    m_seq.delete();
    m_cur = 0; m_left = 0;
    m_pi = 0; m_po = 0; m_dir = 0; m_last = 1;
    m_cnt = '0; m_rd = '0;
  endtask

  task automatic model_step();
    bit ri, ro, g;
    ri = req_in; ro = req_out;
    case (bus.address)
      2'd0:    m_rd = {26'b0, m_po, m_pi, m_dir, 3'(m_cur)};
      2'd1:    m_rd = (m_cur == 0) ? 32'd0 : 32'(m_left - 1);
      2'd2:    m_rd = {16'b0, m_cnt};
      default: m_rd = '0;
    endcase
    if (m_cur == 0) begin
      if (m_pi || m_po) begin
        g = (m_pi && m_po) ? !m_last : m_po;
        m_dir = g; m_last = g;
        if (g) m_seq = '{4, 1, 2, 3};
        else   m_seq = '{1, 2, 3, 4};
        m_cur  = m_seq.pop_front();
        m_left = dur(m_cur);
        if (g) begin m_po = 0; m_pi = m_pi | ri; end
        else   begin m_pi = 0; m_po = m_po | ro; end
      end else begin
        m_pi = m_pi | ri; m_po = m_po | ro;
      end
    end else begin
      m_pi = m_pi | ri; m_po = m_po | ro;
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (m_seq.size() > 0) begin
          m_cur  = m_seq.pop_front();
          m_left = dur(m_cur);
        end else begin
          m_cur = 0;
          m_cnt = m_cnt + 16'd1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; req_in = 1'b0; req_out = 1'b0; bus.address = 2'd0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    req_in = 1'b1; tick(); req_in = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (outs !== 5'b0) begin
      n_fail++; $display("FAIL reset_outs got=%b exp=%b", outs, 5'b0);
    end
    n_tests++;
    if (bus.readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_readdata got=%h exp=%h", bus.readdata, 32'h0);
    end
    @(negedge clk) reset_n = 1'b1;
    bus.address = 2'd0;
    tick(); tick();
    n_tests++;
    if (bus.readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_status got=%h exp=%h", bus.readdata, 32'h0);
    end
  endtask

  task automatic test_entry();
    do_reset();
    req_in = 1'b1; tick(); req_in = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      n_tests++;
      if (outs !== exp_outs()) begin
        n_fail++; $display("FAIL entry_outs cyc=%0d got=%b exp=%b", c, outs, exp_outs());
      end
      n_tests++;
      if (bus.readdata !== m_rd) begin
        n_fail++; $display("FAIL entry_rd cyc=%0d got=%h exp=%h", c, bus.readdata, m_rd);
      end
      if (c == 2 || c == 5) begin
        n_tests++;
        if (filling !== 1'b1) begin
          n_fail++; $display("FAIL entry_fill_edge cyc=%0d got=%b exp=1", c, filling);
        end
      end
      if (c == 17) begin
        n_tests++;
        if (busy !== 1'b0) begin
          n_fail++; $display("FAIL entry_idle got=%b exp=0", busy);
        end
      end
      if (c == 18) begin
        n_tests++;
        if (bus.readdata !== 32'h1) begin
          n_fail++; $display("FAIL entry_count got=%h exp=%h", bus.readdata, 32'h1);
        end
      end
      if (c == 17) bus.address = 2'd2;
      if (c < 18) tick();
    end
  endtask

  task automatic test_exit();
    do_reset();
    bus.address = 2'd1;
    req_out = 1'b1; tick(); req_out = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      n_tests++;
      if (outs !== exp_outs()) begin
        n_fail++; $display("FAIL exit_outs cyc=%0d got=%b exp=%b", c, outs, exp_outs());
      end
      n_tests++;
      if (bus.readdata !== m_rd) begin
        n_fail++; $display("FAIL exit_rd cyc=%0d got=%h exp=%h", c, bus.readdata, m_rd);
      end
      if (c == 2 || c == 4) begin
        n_tests++;
        if (inner_open !== 1'b1) begin
          n_fail++; $display("FAIL exit_inner cyc=%0d got=%b exp=1", c, inner_open);
        end
      end
      if (c == 17) begin
        n_tests++;
        if (busy !== 1'b0) begin
          n_fail++; $display("FAIL exit_idle got=%b exp=0", busy);
        end
      end
      if (c < 18) tick();
    end
  endtask

  task automatic test_tie();
    do_reset();
    req_in = 1'b1; req_out = 1'b1; tick(); req_in = 1'b0; req_out = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      n_tests++;
      if (outs !== exp_outs()) begin
        n_fail++; $display("FAIL tie_outs cyc=%0d got=%b exp=%b", c, outs, exp_outs());
      end
      n_tests++;
      if (bus.readdata !== m_rd) begin
        n_fail++; $display("FAIL tie_rd cyc=%0d got=%h exp=%h", c, bus.readdata, m_rd);
      end
      if (c == 5) begin
        n_tests++;
        if (bus.readdata[5:4] !== 2'b10) begin
          n_fail++; $display("FAIL tie_pend_out got=%b exp=10", bus.readdata[5:4]);
        end
      end
      if (c == 18) begin
        n_tests++;
        if (inner_open !== 1'b1) begin
          n_fail++; $display("FAIL tie_second_exit got=%b exp=1", inner_open);
        end
      end
      if (c < 34) tick();
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_in = 1'b1; tick(); req_in = 1'b0;
    for (int c = 1; c < 18; c++) tick();
    req_in = 1'b1; req_out = 1'b1; tick(); req_in = 1'b0; req_out = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      n_tests++;
      if (outs !== exp_outs()) begin
        n_fail++; $display("FAIL rr_outs cyc=%0d got=%b exp=%b", c, outs, exp_outs());
      end
      if (c == 2) begin
        n_tests++;
        if (inner_open !== 1'b1) begin
          n_fail++; $display("FAIL rr_exit_first got=%b exp=1", inner_open);
        end
      end
      if (c == 18) begin
        n_tests++;
        if (filling !== 1'b1) begin
          n_fail++; $display("FAIL rr_entry_next got=%b exp=1", filling);
        end
      end
      if (c < 19) tick();
    end
  endtask

  task automatic test_pending_busy();
    do_reset();
    req_in = 1'b1; tick(); req_in = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      n_tests++;
      if (outs !== exp_outs()) begin
        n_fail++; $display("FAIL pend_outs cyc=%0d got=%b exp=%b", c, outs, exp_outs());
      end
      if (c == 18) begin
        n_tests++;
        if (filling !== 1'b1) begin
          n_fail++; $display("FAIL pend_second_fill got=%b exp=1", filling);
        end
      end
      if (c == 34) begin
        n_tests++;
        if (bus.readdata !== 32'h2) begin
          n_fail++; $display("FAIL pend_count got=%h exp=%h", bus.readdata, 32'h2);
        end
      end
      req_in = (c == 4);
      if (c == 33) bus.address = 2'd2;
      if (c < 34) tick();
    end
    req_in = 1'b0;
  endtask

  task automatic test_reset_drain();
    do_reset();
    req_in = 1'b1; tick(); req_in = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    req_out = 1'b1; tick(); req_out = 1'b0;
    n_tests++;
    if (draining !== 1'b1) begin
      n_fail++; $display("FAIL rstdrain_pre got=%b exp=1", draining);
    end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({outs, bus.readdata} !== 37'b0) begin
      n_fail++; $display("FAIL rstdrain_async got=%b/%h exp=0/0", outs, bus.readdata);
    end
    @(negedge clk) reset_n = 1'b1;
    bus.address = 2'd0;
    tick();
    n_tests++;
    if (bus.readdata !== 32'h0) begin
      n_fail++; $display("FAIL rstdrain_pends got=%h exp=%h", bus.readdata, 32'h0);
    end
    req_out = 1'b1; tick(); req_out = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      n_tests++;
      if (outs !== exp_outs()) begin
        n_fail++; $display("FAIL rstdrain_exit cyc=%0d got=%b exp=%b", c, outs, exp_outs());
      end
      n_tests++;
      if (bus.readdata !== m_rd) begin
        n_fail++; $display("FAIL rstdrain_rd cyc=%0d got=%h exp=%h", c, bus.readdata, m_rd);
      end
      if (c < 18) tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      req_in      = ($urandom_range(0, 11) == 0);
      req_out     = ($urandom_range(0, 11) == 0);
      bus.address = 2'($urandom_range(0, 3));
      tick();
      n_tests++;
      if (outs !== exp_outs()) begin
        n_fail++; $display("FAIL rand_outs cyc=%0d got=%b exp=%b", c, outs, exp_outs());
      end
      n_tests++;
      if (bus.readdata !== m_rd) begin
        n_fail++; $display("FAIL rand_rd cyc=%0d got=%h exp=%h", c, bus.readdata, m_rd);
      end
    end
    req_in = 1'b0; req_out = 1'b0;
  endtask

  initial begin
    bus.address = 2'd0;
    model_reset();
    test_reset();
    test_entry();
    test_exit();
    test_tie();
    test_round_robin();
    test_pending_busy();
    test_reset_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
